// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures the rising-to-rising period of an asynchronous
// input (mon_in) in clk cycles, classifies each period against expected_period
// +/- TOL, tracks lock/stuck status and a saturating error counter.
// Optional min/max period statistics are built when the macro
// CLK_PERIOD_MONITOR_STATS_EN is defined; otherwise period_min/period_max are 0.
module clk_period_monitor #(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear_err,
    input  logic                 mon_in,
    input  logic [CNT_WIDTH-1:0] expected_period,
    output logic                 period_valid,
    output logic [CNT_WIDTH-1:0] period_value,
    output logic                 err_short,
    output logic                 err_long,
    output logic                 stuck,
    output logic                 locked,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] period_min,
    output logic [CNT_WIDTH-1:0] period_max
);

    localparam int unsigned GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [GW-1:0] LC    = GW'(LOCK_COUNT);
    localparam logic [GW-1:0] LC_M1 = GW'(LOCK_COUNT - 1);
    localparam logic [CNT_WIDTH:0] TOL_EXT = (CNT_WIDTH + 1)'(TOL);
    localparam logic [CNT_WIDTH:0] MAX_EXT = {1'b0, {CNT_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        MEASURE
    } state_t;

    state_t state, state_next;

    logic                 sync1, sync2, hist;
    logic                 edge_det;
    logic [CNT_WIDTH-1:0] counter;
    logic [GW-1:0]        good_cnt;
    logic                 first_edge, meas_edge, saturate;
    logic [CNT_WIDTH:0]   cnt_ext, exp_ext, lo_bound, hi_sum, hi_bound;
    logic                 is_short, is_long, period_good, err_event;

    // Two-flop synchronizer plus history flop for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= mon_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign edge_det = sync2 & ~hist;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and per-cycle event decode
    always_comb begin
        state_next = state;
        first_edge = 1'b0;
        meas_edge  = 1'b0;
        saturate   = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = WAIT_FIRST;
                WAIT_FIRST: begin
                    if (edge_det) begin
                        first_edge = 1'b1;
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_det) begin
                        meas_edge = 1'b1;
                    end else if (counter == '1) begin
                        saturate   = 1'b1;
                        state_next = WAIT_FIRST;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Period classification in CNT_WIDTH+1 bits with clamped bounds
    always_comb begin
        cnt_ext  = {1'b0, counter};
        exp_ext  = {1'b0, expected_period};
        lo_bound = (exp_ext >= TOL_EXT) ? (exp_ext - TOL_EXT) : '0;
        hi_sum   = exp_ext + TOL_EXT;
        hi_bound = (hi_sum > MAX_EXT) ? MAX_EXT : hi_sum;
        is_short    = cnt_ext < lo_bound;
        is_long     = cnt_ext > hi_bound;
        period_good = ~is_short & ~is_long;
        err_event   = saturate | (meas_edge & ~period_good);
    end

    // Period counter: restarts at 1 on each edge, counts while measuring
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
        end else if (!enable) begin
            counter <= '0;
        end else if (first_edge || meas_edge) begin
            counter <= CNT_WIDTH'(1);
        end else if (state == MEASURE && !saturate) begin
            counter <= counter + CNT_WIDTH'(1);
        end else begin
            counter <= '0;
        end
    end

    // Measurement result and one-cycle classification pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_valid <= 1'b0;
            err_short    <= 1'b0;
            err_long     <= 1'b0;
            period_value <= '0;
        end else begin
            period_valid <= meas_edge;
            err_short    <= meas_edge & is_short;
            err_long     <= meas_edge & is_long;
            if (meas_edge) period_value <= counter;
        end
    end

    // Stuck, lock and consecutive-good tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuck    <= 1'b0;
            locked   <= 1'b0;
            good_cnt <= '0;
        end else if (!enable || saturate) begin
            stuck    <= saturate;
            locked   <= 1'b0;
            good_cnt <= '0;
        end else begin
            if (first_edge || meas_edge) stuck <= 1'b0;
            if (meas_edge) begin
                if (period_good) begin
                    if (good_cnt < LC) good_cnt <= good_cnt + GW'(1);
                    if (good_cnt >= LC_M1) locked <= 1'b1;
                end else begin
                    good_cnt <= '0;
                    locked   <= 1'b0;
                end
            end
        end
    end

    // Saturating error counter; clear_err wins but still counts a coincident error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (clear_err) begin
            err_count <= err_event ? ERR_WIDTH'(1) : '0;
        end else if (err_event && err_count != '1) begin
            err_count <= err_count + ERR_WIDTH'(1);
        end
    end

`ifdef CLK_PERIOD_MONITOR_STATS_EN
    // Min/max statistics; a period coinciding with clear_err seeds both
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_min <= '1;
            period_max <= '0;
        end else if (clear_err) begin
            period_min <= meas_edge ? counter : '1;
            period_max <= meas_edge ? counter : '0;
        end else if (meas_edge) begin
            if (counter < period_min) period_min <= counter;
            if (counter > period_max) period_max <= counter;
        end
    end
`else
    assign period_min = '0;
    assign period_max = '0;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// Testbench for clk_period_monitor: drives clk-aligned mon_in waveforms with
// randomized periods and checks every measurement against a period-list model.
module tb_clk_period_monitor;

    logic        clk = 1'b0;
    logic        rst, enable, clear_err, mon_in;
    logic [15:0] expected_period;
    logic        period_valid, err_short, err_long, stuck, locked;
    logic [15:0] period_value, period_min, period_max;
    logic [7:0]  err_count;

    int tests_run = 0;
    int tests_failed = 0;
    int proto_bad = 0;

    typedef struct packed {
        logic [15:0] pv;
        logic        s;
        logic        l;
        logic        lk;
        logic [7:0]  ec;
    } rec_t;

    rec_t got_q[$];
    rec_t exp_q[$];
    rec_t cap_r;

    // model state
    int unsigned cur_exp = 10;
    int unsigned m_err = 0, m_good = 0, m_pv = 0;
    int unsigned m_min = 65535, m_max = 0;
    bit          m_locked = 0;

    clk_period_monitor #(
        .CNT_WIDTH(16),
        .TOL(1),
        .LOCK_COUNT(4),
        .ERR_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .clear_err(clear_err),
        .mon_in(mon_in),
        .expected_period(expected_period),
        .period_valid(period_valid),
        .period_value(period_value),
        .err_short(err_short),
        .err_long(err_long),
        .stuck(stuck),
        .locked(locked),
        .err_count(err_count),
        .period_min(period_min),
        .period_max(period_max)
    );

    always #5 clk = ~clk;

    // capture every measurement and watch pulse consistency
    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            cap_r.pv = period_value;
            cap_r.s  = err_short;
            cap_r.l  = err_long;
            cap_r.lk = locked;
            cap_r.ec = err_count;
            got_q.push_back(cap_r);
        end
        if ((err_short || err_long) && period_valid !== 1'b1) proto_bad++;
        if (err_short && err_long) proto_bad++;
    end

    function automatic void model_period(input int unsigned p);
        longint lo, hi;
        rec_t r;
        lo = (cur_exp >= 1) ? longint'(cur_exp) - 1 : 0;
        hi = longint'(cur_exp) + 1;
        if (hi > 65535) hi = 65535;
        r.s = (p < lo);
        r.l = (p > hi);
        if (!r.s && !r.l) begin
            if (m_good < 4) m_good++;
            if (m_good >= 4) m_locked = 1;
        end else begin
            m_good = 0;
            m_locked = 0;
            if (m_err < 255) m_err++;
        end
        r.pv = p[15:0];
        r.lk = m_locked;
        r.ec = m_err[7:0];
        m_pv = p;
        if (p < m_min) m_min = p;
        if (p > m_max) m_max = p;
        exp_q.push_back(r);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one rising edge of mon_in followed by a full period of p clk cycles
    task automatic pulse_mon(input int unsigned p);
        mon_in = 1'b1;
        tick(int'(p / 2));
        mon_in = 1'b0;
        tick(int'(p - p / 2));
    endtask

    task automatic start_mon(input int unsigned e);
        enable = 1'b0;
        cur_exp = e;
        expected_period = cur_exp[15:0];
        tick(2);
        enable = 1'b1;
        tick(4);
    endtask

    task automatic stop_mon();
        enable = 1'b0;
        tick(3);
        m_good = 0;
        m_locked = 0;
    endtask

    task automatic run_intervals(input int unsigned lst[$]);
        foreach (lst[i]) begin
            pulse_mon(lst[i]);
            model_period(lst[i]);
        end
        pulse_mon(4);
        tick(4);
    endtask

    task automatic test_reset();
        logic [15:0] min_exp;
`ifdef CLK_PERIOD_MONITOR_STATS_EN
        min_exp = 16'hFFFF;
`else
        min_exp = 16'h0000;
`endif
        #1;
        tests_run++;
        if ({period_valid, err_short, err_long, stuck, locked} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {period_valid, err_short, err_long, stuck, locked});
        end
        tests_run++;
        if (period_value !== 16'd0 || err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got pv=%0d ec=%0d expected 0 0", period_value, err_count);
        end
        tests_run++;
        if (period_min !== min_exp || period_max !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_stats: got min=%0d max=%0d expected %0d 0", period_min, period_max, min_exp);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_lock();
        start_mon(10);
        run_intervals('{10, 10, 10, 10, 10});
        stop_mon();
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL lock_count: got %0d pulses expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL lock_pulse%0d: got pv=%0d s=%b l=%b lk=%b ec=%0d expected pv=%0d s=%b l=%b lk=%b ec=%0d",
                         i, got_q[i].pv, got_q[i].s, got_q[i].l, got_q[i].lk, got_q[i].ec,
                         exp_q[i].pv, exp_q[i].s, exp_q[i].l, exp_q[i].lk, exp_q[i].ec);
            end
        end
`ifdef CLK_PERIOD_MONITOR_STATS_EN
        tests_run++;
        if (period_min !== m_min[15:0] || period_max !== m_max[15:0]) begin
            tests_failed++;
            $display("FAIL lock_stats: got min=%0d max=%0d expected %0d %0d", period_min, period_max, m_min, m_max);
        end
`endif
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_short_long();
        start_mon(10);
        run_intervals('{10, 10, 8, 10});
        stop_mon();
        start_mon(10);
        run_intervals('{11, 12});
        stop_mon();
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL shortlong_count: got %0d pulses expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL shortlong_pulse%0d: got pv=%0d s=%b l=%b lk=%b ec=%0d expected pv=%0d s=%b l=%b lk=%b ec=%0d",
                         i, got_q[i].pv, got_q[i].s, got_q[i].l, got_q[i].lk, got_q[i].ec,
                         exp_q[i].pv, exp_q[i].s, exp_q[i].l, exp_q[i].lk, exp_q[i].ec);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        int unsigned e, lst[$];
        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 5))
                0: e = 0;
                1: e = 1;
                2: e = 65535;
                default: e = $urandom_range(7, 20);
            endcase
            lst.delete();
            for (int k = 0; k < 8; k++) begin
                if (e >= 7 && e <= 20) lst.push_back($urandom_range(e - 3, e + 3));
                else lst.push_back($urandom_range(4, 12));
            end
            start_mon(e);
            run_intervals(lst);
            stop_mon();
        end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL random_count: got %0d pulses expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL random_pulse%0d: got pv=%0d s=%b l=%b lk=%b ec=%0d expected pv=%0d s=%b l=%b lk=%b ec=%0d",
                         i, got_q[i].pv, got_q[i].s, got_q[i].l, got_q[i].lk, got_q[i].ec,
                         exp_q[i].pv, exp_q[i].s, exp_q[i].l, exp_q[i].lk, exp_q[i].ec);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_enable_drop();
        start_mon(10);
        pulse_mon(8);
        enable = 1'b0;
        tick(2);
        mon_in = 1'b1;
        tick(3);
        mon_in = 1'b0;
        tick(3);
        tests_run++;
        if (got_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drop_pulse: got %0d pulses expected 0", got_q.size());
        end
        tests_run++;
        if (locked !== 1'b0 || stuck !== 1'b0 || err_count !== m_err[7:0] || period_value !== m_pv[15:0]) begin
            tests_failed++;
            $display("FAIL drop_hold: got lk=%b st=%b ec=%0d pv=%0d expected 0 0 %0d %0d",
                     locked, stuck, err_count, period_value, m_err, m_pv);
        end
        stop_mon();
        got_q.delete();
    endtask

    task automatic test_err_saturate();
        int unsigned lst[$];
        for (int k = 0; k < 260; k++) lst.push_back(5);
        start_mon(10);
        run_intervals(lst);
        stop_mon();
        tests_run++;
        if (err_count !== 8'd255) begin
            tests_failed++;
            $display("FAIL sat_errcount: got %0d expected 255", err_count);
        end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL sat_count: got %0d pulses expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL sat_pulse%0d: got pv=%0d s=%b l=%b ec=%0d expected pv=%0d s=%b l=%b ec=%0d",
                         i, got_q[i].pv, got_q[i].s, got_q[i].l, got_q[i].ec,
                         exp_q[i].pv, exp_q[i].s, exp_q[i].l, exp_q[i].ec);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_clear_coincident();
        start_mon(10);
        pulse_mon(5);
        // clear_err spans the whole synchronizer latency of the second edge
        mon_in = 1'b1;
        clear_err = 1'b1;
        tick(3);
        clear_err = 1'b0;
        tick(1);
        mon_in = 1'b0;
        tick(4);
        m_err = 0;
        m_min = 65535;
        m_max = 0;
        model_period(5);
        stop_mon();
        tests_run++;
        if (err_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL clear_errcount: got %0d expected 1", err_count);
        end
        tests_run++;
        if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin
            tests_failed++;
            $display("FAIL clear_pulse: got %0d pulses ec=%0d expected 1 pulse short ec=%0d",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].ec : 8'd0, exp_q[0].ec);
        end
`ifdef CLK_PERIOD_MONITOR_STATS_EN
        tests_run++;
        if (period_min !== 16'd5 || period_max !== 16'd5) begin
            tests_failed++;
            $display("FAIL clear_stats: got min=%0d max=%0d expected 5 5", period_min, period_max);
        end
`endif
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stuck();
        int waited;
        start_mon(10);
        pulse_mon(4);
        waited = 0;
        while (stuck !== 1'b1 && waited < 70000) begin
            tick(1);
            waited++;
        end
        if (m_err < 255) m_err++;
        m_good = 0;
        m_locked = 0;
        tests_run++;
        if (stuck !== 1'b1 || waited < 65532 || waited > 65536) begin
            tests_failed++;
            $display("FAIL stuck_set: got stuck=%b after %0d cycles expected 1 after about 65534", stuck, waited);
        end
        tests_run++;
        if (err_count !== m_err[7:0] || locked !== 1'b0 || got_q.size() != 0) begin
            tests_failed++;
            $display("FAIL stuck_err: got ec=%0d lk=%b pulses=%0d expected ec=%0d lk=0 pulses=0",
                     err_count, locked, got_q.size(), m_err);
        end
        pulse_mon(10);
        tests_run++;
        if (stuck !== 1'b0) begin
            tests_failed++;
            $display("FAIL stuck_clear: got %b expected 0", stuck);
        end
        pulse_mon(4);
        tick(4);
        model_period(10);
        stop_mon();
        tests_run++;
        if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin
            tests_failed++;
            $display("FAIL stuck_remeasure: got %0d pulses pv=%0d expected 1 pulse pv=10",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].pv : 16'd0);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        start_mon(10);
        for (int k = 0; k < 5; k++) pulse_mon(10);
        mon_in = 1'b1;
        tick(5);
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_locked: got %b expected 1", locked);
        end
        got_q.delete();
        #2;
        rst = 1'b1;
        mon_in = 1'b0;
        #1;
        tests_run++;
        if ({period_valid, err_short, err_long, stuck, locked} !== 5'b0 ||
            period_value !== 16'd0 || err_count !== 8'd0 || period_max !== 16'd0) begin
            tests_failed++;
            $display("FAIL rstmid_async: got flags=%b pv=%0d ec=%0d max=%0d expected all 0",
                     {period_valid, err_short, err_long, stuck, locked}, period_value, err_count, period_max);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_err = 0; m_good = 0; m_locked = 0; m_pv = 0; m_min = 65535; m_max = 0;
        tick(3);
        pulse_mon(10);
        tests_run++;
        if (got_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rstmid_first_edge: got %0d pulses expected 0", got_q.size());
        end
        pulse_mon(4);
        tick(4);
        model_period(10);
        stop_mon();
        tests_run++;
        if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin
            tests_failed++;
            $display("FAIL rstmid_second_edge: got %0d pulses pv=%0d expected 1 pulse pv=10",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].pv : 16'd0);
        end
`ifdef CLK_PERIOD_MONITOR_STATS_EN
        tests_run++;
        if (period_min !== 16'd10 || period_max !== 16'd10) begin
            tests_failed++;
            $display("FAIL rstmid_stats: got min=%0d max=%0d expected 10 10", period_min, period_max);
        end
`endif
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_pulse_exclusive();
        tests_run++;
        if (proto_bad != 0) begin
            tests_failed++;
            $display("FAIL pulse_exclusive: got %0d bad pulse cycles expected 0", proto_bad);
        end
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        clear_err = 1'b0;
        mon_in = 1'b0;
        expected_period = 16'd10;
        #1;
        rst = 1'b1;
        test_reset();
        test_lock();
        test_short_long();
        test_random();
        test_enable_drop();
        test_err_saturate();
        test_clear_coincident();
        test_stuck();
        test_reset_mid();
        test_pulse_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clk_period_monitor.md
CLK_PERIOD_MONITOR -- requirements
Module: clk_period_monitor

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of the period counter and of the period fields.
REQ-002 SHALL have parameter TOL, default 1: allowed deviation, in clk cycles, of a good period from expected_period.
REQ-003 SHALL have parameter LOCK_COUNT, default 4: number of consecutive good periods required to assert locked.
REQ-004 SHALL have parameter ERR_WIDTH, default 8: width of err_count.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port enable, input, 1 bit: when high, monitoring runs.
REQ-008 SHALL have port clear_err, input, 1 bit: synchronous pulse that clears err_count and the statistics.
REQ-009 SHALL have port mon_in, input, 1 bit: monitored clock, asynchronous to clk.
REQ-010 SHALL have port expected_period, input, CNT_WIDTH bits: nominal rising-to-rising period, in clk cycles.
REQ-011 SHALL have port period_valid, output, 1 bit: one-cycle pulse that marks a completed measurement.
REQ-012 SHALL have port period_value, output, CNT_WIDTH bits: the last measured period.
REQ-013 SHALL have port err_short, output, 1 bit: one-cycle pulse meaning period < expected_period-TOL.
REQ-014 SHALL have port err_long, output, 1 bit: one-cycle pulse meaning period > expected_period+TOL.
REQ-015 SHALL have port stuck, output, 1 bit: level meaning no edge arrived before the counter saturated.
REQ-016 SHALL have port locked, output, 1 bit: level meaning at least LOCK_COUNT consecutive good periods.
REQ-017 SHALL have port err_count, output, ERR_WIDTH bits: saturating error counter.
REQ-018 SHALL have ports period_min and period_max, output, CNT_WIDTH bits each: statistics (see Configuration).

Function
REQ-019 SHALL pass mon_in through a 2-flop synchronizer plus a history flop, and SHALL form edge = sync & ~hist.
REQ-020 SHALL implement a state machine with states IDLE, WAIT_FIRST and MEASURE.
- Any state -> IDLE while enable=0.
- IDLE -> WAIT_FIRST when enable=1.
- WAIT_FIRST -> MEASURE on edge.
- MEASURE -> WAIT_FIRST on saturation.
REQ-021 SHALL load the counter with 1 on an edge cycle and SHALL increment it by 1 on every other MEASURE cycle; therefore edges N cycles apart yield period N.
REQ-022 SHALL, on an edge in MEASURE, register period_value = counter and SHALL pulse period_valid exactly one clk cycle after the edge cycle.
REQ-023 SHALL compute the good/short/long classification with CNT_WIDTH+1-bit arithmetic; expected_period-TOL SHALL clamp at 0 and expected_period+TOL SHALL clamp at all-ones.
REQ-024 SHALL assert err_short or err_long in the same cycle as period_valid; the two SHALL never be high together.
REQ-025 SHALL, when the counter reaches all-ones with no edge, set stuck=1, clear locked, increment err_count and move to WAIT_FIRST.
REQ-026 SHALL clear stuck on the next edge.
REQ-027 SHALL increment a consecutive-good counter on each good period, saturating at LOCK_COUNT, and SHALL set locked=1 on the period_valid cycle on which the count reaches LOCK_COUNT.
REQ-028 SHALL, on any bad period or stuck event, clear locked and the consecutive-good counter.
REQ-029 SHALL increment err_count by 1 per error event and SHALL saturate it at all-ones.
REQ-030 SHALL give clear_err priority when clear_err and an error coincide; err_count SHALL then be 1.
REQ-031 SHALL, while enable=0, hold the counter at 0, hold locked, stuck and all pulses at 0, and retain err_count and period_value.
REQ-032 SHALL, when enable drops mid-measurement, discard the partial period with no pulse.

Reset
REQ-033 SHALL, on rst=1, immediately and asynchronously force state IDLE and clear all flops.
REQ-034 SHALL, during reset, drive every output to 0, except period_min, which SHALL be all-ones when statistics are enabled.
REQ-035 SHALL resume on the first clk edge after rst deasserts; a reset mid-measurement SHALL produce no pulse.

Configuration
REQ-036 SHALL compile statistics logic only when macro CLK_PERIOD_MONITOR_STATS_EN is defined.
REQ-037 SHALL, when CLK_PERIOD_MONITOR_STATS_EN is defined, update period_min and period_max on each period_valid, and clear_err SHALL reset them to all-ones and 0 respectively.
REQ-038 SHALL, when CLK_PERIOD_MONITOR_STATS_EN is undefined, keep both ports and tie them to constant 0.

Verification (expected_period=10, TOL=1, LOCK_COUNT=4, CNT_WIDTH=16)
REQ-039 SHALL cover: mon_in period 10 clk, 6 edges -> period_value=10 on every pulse; locked rises on the 4th pulse; err_count=0.
REQ-040 SHALL cover: mon_in periods 10,10,8,10 -> err_short on the 3rd pulse only; locked stays 0; err_count=1.
REQ-041 SHALL cover: periods 11 then 12 -> the first is good; the second pulses err_long.
REQ-042 SHALL cover: mon_in held low after one edge for 65535+ cycles -> stuck=1 and err_count+1; the next edges give stuck=0 and a new measurement.
REQ-043 SHALL cover: err_count at 255 plus a further error -> value stays 255; clear_err coincident with an error -> value 1.
REQ-044 SHALL cover: rst asserted mid-period while locked -> outputs 0 with no clk edge required; first period_valid appears only after two post-reset edges.
